// File: rtl/tl_pkg.sv
// Shared TL types for the tag allocator and its neighbours.
package tl_pkg;

    // Default number of managed non-posted tags.
    localparam int unsigned TL_TAG_MAX = 32;

    // Per-request metadata kept alongside each outstanding tag.
    typedef struct packed {
        logic [9:0] len_dw;
        logic [5:0] user_id;
    } tl_tag_meta_t;

endpackage

// File: rtl/tl_lsb_find.sv
// Lowest-set-bit finder: index of the least significant 1 plus a found flag.
module tl_lsb_find #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_tag_table.sv
// Non-posted request tag allocator for the TL transmit path.
// Offers the lowest free tag, records metadata on consume, returns it on completion and frees
// the tag on the final completion. Optional per-tag timeout is built when TL_TAG_TIMEOUT_EN is
// defined; the default build has no age counters and no tmo_* ports.
module tl_tag_table
    import tl_pkg::*;
#(
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned NUM_TAGS = TL_TAG_MAX,
    parameter int unsigned META_W   = $bits(tl_tag_meta_t)
`ifdef TL_TAG_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W    = 4,
    parameter int unsigned TMO_TICK = 1024
`endif
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic [TAG_W-1:0]                 tag_o,
    output logic                             tag_valid_o,
    input  logic                             tag_consume_i,
    input  logic [META_W-1:0]                alloc_meta_i,
    input  logic                             cpl_valid_i,
    input  logic [TAG_W-1:0]                 cpl_tag_i,
    input  logic                             cpl_last_i,
    output logic                             cpl_rsp_valid_o,
    output logic [TAG_W-1:0]                 cpl_rsp_tag_o,
    output logic [META_W-1:0]                cpl_rsp_meta_o,
    output logic                             cpl_rsp_err_o,
    output logic [$clog2(NUM_TAGS+1)-1:0]    outstanding_o,
    output logic                             alloc_err_o
`ifdef TL_TAG_TIMEOUT_EN
    ,
    output logic                             tmo_valid_o,
    output logic [TAG_W-1:0]                 tmo_tag_o
`endif
);

    localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [NUM_TAGS-1:0] consume_mask, cpl_mask, release_mask, tmo_mask;
    logic                consume_ok, cpl_hit, cpl_rel, tmo_fire;
    logic [META_W-1:0]   meta_q [NUM_TAGS];
    logic [META_W-1:0]   meta_rd;
    logic [TAG_W-1:0]    tag_q, tag_d, free_idx;
    logic                tag_valid_q, tag_valid_d, free_found;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic [META_W-1:0]   rsp_meta_q, rsp_meta_d;
    logic                alloc_err_q, alloc_err_d;

    // Decode consume and completion into one-hot masks; out-of-range tags decode to zero.
    always_comb begin
        consume_ok = tag_consume_i & tag_valid_q;
        meta_rd    = '0;
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            consume_mask[i] = consume_ok & (tag_q == TAG_W'(i));
            cpl_mask[i]     = cpl_valid_i & (cpl_tag_i == TAG_W'(i));
            if (cpl_mask[i]) begin
                meta_rd = meta_q[i];
            end
        end
        cpl_hit = |(busy_q & cpl_mask);
        cpl_rel = cpl_valid_i & cpl_last_i & cpl_hit;
    end

`ifdef TL_TAG_TIMEOUT_EN
    localparam int unsigned PRE_W = (TMO_TICK > 1) ? $clog2(TMO_TICK) : 1;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick;
    logic [TMO_W-1:0]    age_q [NUM_TAGS];
    logic [TMO_W-1:0]    age_d [NUM_TAGS];
    logic [NUM_TAGS-1:0] expired;
    logic [TAG_W-1:0]    exp_idx;
    logic                exp_found;
    logic                tmo_valid_q, tmo_valid_d;
    logic [TAG_W-1:0]    tmo_tag_q, tmo_tag_d;

    // Prescaler and per-tag saturating ages; a completion to the expiring tag wins.
    always_comb begin
        tick  = (pre_q == PRE_W'(TMO_TICK - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            expired[i] = busy_q[i] & (&age_q[i]);
            age_d[i]   = age_q[i];
            if (consume_mask[i]) begin
                age_d[i] = '0;
            end else if (busy_q[i] && tick && !(&age_q[i])) begin
                age_d[i] = age_q[i] + TMO_W'(1);
            end
        end
        tmo_fire = exp_found & ~(cpl_valid_i & cpl_hit & (cpl_tag_i == exp_idx));
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            tmo_mask[i] = tmo_fire & (exp_idx == TAG_W'(i));
        end
        tmo_valid_d = tmo_fire;
        tmo_tag_d   = tmo_fire ? exp_idx : tmo_tag_q;
    end

    tl_lsb_find #(
        .N     (NUM_TAGS),
        .IDX_W (TAG_W)
    ) u_exp_find (
        .vec_i   (expired),
        .idx_o   (exp_idx),
        .found_o (exp_found)
    );

    // Timeout state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            tmo_valid_q <= 1'b0;
            tmo_tag_q   <= '0;
            for (int i = 0; i < int'(NUM_TAGS); i++) age_q[i] <= '0;
        end else begin
            pre_q       <= pre_d;
            tmo_valid_q <= tmo_valid_d;
            tmo_tag_q   <= tmo_tag_d;
            for (int i = 0; i < int'(NUM_TAGS); i++) age_q[i] <= age_d[i];
        end
    end

    assign tmo_valid_o = tmo_valid_q;
    assign tmo_tag_o   = tmo_tag_q;
`else
    assign tmo_fire = 1'b0;
    assign tmo_mask = '0;
`endif

    // Next bitmap, counter, offered tag and completion response.
    always_comb begin
        release_mask = (cpl_rel ? cpl_mask : '0) | tmo_mask;
        busy_d       = (busy_q | consume_mask) & ~release_mask;
        cnt_d        = cnt_q + CNT_W'(consume_ok) - CNT_W'(cpl_rel) - CNT_W'(tmo_fire);
        tag_valid_d  = free_found;
        tag_d        = free_found ? free_idx : tag_q;
        alloc_err_d  = alloc_err_q | (tag_consume_i & ~tag_valid_q);
        rsp_valid_d  = cpl_valid_i;
        rsp_tag_d    = rsp_tag_q;
        rsp_meta_d   = rsp_meta_q;
        rsp_err_d    = rsp_err_q;
        if (cpl_valid_i) begin
            rsp_tag_d  = cpl_tag_i;
            rsp_meta_d = meta_rd;
            rsp_err_d  = ~cpl_hit;
        end
    end

    tl_lsb_find #(
        .N     (NUM_TAGS),
        .IDX_W (TAG_W)
    ) u_free_find (
        .vec_i   (~busy_d),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b1;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_meta_q  <= '0;
            rsp_err_q   <= 1'b0;
            alloc_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_meta_q  <= rsp_meta_d;
            rsp_err_q   <= rsp_err_d;
            alloc_err_q <= alloc_err_d;
        end
    end

    // Metadata storage; deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            if (consume_mask[i]) meta_q[i] <= alloc_meta_i;
        end
    end

    assign tag_o           = tag_q;
    assign tag_valid_o     = tag_valid_q;
    assign outstanding_o   = cnt_q;
    assign alloc_err_o     = alloc_err_q;
    assign cpl_rsp_valid_o = rsp_valid_q;
    assign cpl_rsp_tag_o   = rsp_tag_q;
    assign cpl_rsp_meta_o  = rsp_meta_q;
    assign cpl_rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_tl_tag_table.sv
// Scoreboard bench for tl_tag_table: directed scenarios plus randomized traffic against a
// set-based reference model. Builds the timeout scenario when TL_TAG_TIMEOUT_EN is defined.
module tb_tl_tag_table;

    localparam int unsigned TAG_W    = 4;
    localparam int unsigned NUM_TAGS = 6;
    localparam int unsigned META_W   = 16;
    localparam int unsigned CNT_W    = $clog2(NUM_TAGS + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [TAG_W-1:0]  tag_o;
    logic              tag_valid_o;
    logic              tag_consume_i = 1'b0;
    logic [META_W-1:0] alloc_meta_i = '0;
    logic              cpl_valid_i = 1'b0;
    logic [TAG_W-1:0]  cpl_tag_i = '0;
    logic              cpl_last_i = 1'b0;
    logic              cpl_rsp_valid_o;
    logic [TAG_W-1:0]  cpl_rsp_tag_o;
    logic [META_W-1:0] cpl_rsp_meta_o;
    logic              cpl_rsp_err_o;
    logic [CNT_W-1:0]  outstanding_o;
    logic              alloc_err_o;
`ifdef TL_TAG_TIMEOUT_EN
    logic              tmo_valid_o;
    logic [TAG_W-1:0]  tmo_tag_o;
`endif

    always #5 clk = ~clk;

    tl_tag_table #(
        .TAG_W    (TAG_W),
        .NUM_TAGS (NUM_TAGS),
        .META_W   (META_W)
`ifdef TL_TAG_TIMEOUT_EN
        ,
        .TMO_W    (2),
        .TMO_TICK (4)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tag_o           (tag_o),
        .tag_valid_o     (tag_valid_o),
        .tag_consume_i   (tag_consume_i),
        .alloc_meta_i    (alloc_meta_i),
        .cpl_valid_i     (cpl_valid_i),
        .cpl_tag_i       (cpl_tag_i),
        .cpl_last_i      (cpl_last_i),
        .cpl_rsp_valid_o (cpl_rsp_valid_o),
        .cpl_rsp_tag_o   (cpl_rsp_tag_o),
        .cpl_rsp_meta_o  (cpl_rsp_meta_o),
        .cpl_rsp_err_o   (cpl_rsp_err_o),
        .outstanding_o   (outstanding_o),
        .alloc_err_o     (alloc_err_o)
`ifdef TL_TAG_TIMEOUT_EN
        ,
        .tmo_valid_o     (tmo_valid_o),
        .tmo_tag_o       (tmo_tag_o)
`endif
    );

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [META_W-1:0] meta;
        logic              err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: set of busy tags, stored metadata, counters.
    bit                m_busy [NUM_TAGS];
    logic [META_W-1:0] m_meta [NUM_TAGS];
    int                m_cnt;
    int                m_tag;
    bit                m_valid;
    bit                m_aerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_pick();
        m_valid = 1'b0;
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            if (!m_busy[i]) begin
                m_tag   = i;
                m_valid = 1'b1;
                break;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < int'(NUM_TAGS); i++) m_busy[i] = 1'b0;
        m_cnt  = 0;
        m_tag  = 0;
        m_aerr = 1'b0;
        model_pick();
    endfunction

    // One clock: check present status, drive inputs, advance the model, return after the edge.
    task automatic cycle(input bit cons, input logic [META_W-1:0] meta, input bit cv,
                         input int ctag, input bit last);
        rsp_t r;
        bit   err;
        @(negedge clk);
        chk("tag_valid", tag_valid_o, m_valid);
        chk("tag", tag_o, m_tag);
        chk("outstanding", outstanding_o, m_cnt);
        chk("alloc_err", alloc_err_o, m_aerr);
        tag_consume_i = cons;
        alloc_meta_i  = meta;
        cpl_valid_i   = cv;
        cpl_tag_i     = TAG_W'(ctag);
        cpl_last_i    = last;
        if (cv) begin
            err = 1'b1;
            if (ctag < int'(NUM_TAGS)) err = !m_busy[ctag];
            r.tag  = TAG_W'(ctag);
            r.err  = err;
            r.meta = err ? '0 : m_meta[ctag];
            exp_q.push_back(r);
            if (!err && last) begin
                m_busy[ctag] = 1'b0;
                m_cnt--;
            end
        end
        if (cons) begin
            if (m_valid) begin
                m_busy[m_tag] = 1'b1;
                m_meta[m_tag] = meta;
                m_cnt++;
            end else begin
                m_aerr = 1'b1;
            end
        end
        model_pick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every presented response must match the oldest expectation.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && cpl_rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got tag %0d with nothing expected",
                             cpl_rsp_tag_o);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_tag", cpl_rsp_tag_o, r.tag);
                    chk("rsp_err", cpl_rsp_err_o, r.err);
                    if (!r.err) chk("rsp_meta", cpl_rsp_meta_o, r.meta);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef TL_TAG_TIMEOUT_EN
        int tmo_tags [2];
        int tmo_cyc  [2];
        int n_tmo;
`else
        bit   rc, rv, rl;
        int   rt;
        int   bt;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset tag_valid", tag_valid_o, 1);
        chk("reset tag", tag_o, 0);
        chk("reset outstanding", outstanding_o, 0);
        chk("reset alloc_err", alloc_err_o, 0);

`ifdef TL_TAG_TIMEOUT_EN
        cycle(1'b1, 16'h0010, 1'b0, 0, 1'b0);
        cycle(1'b1, 16'h0020, 1'b0, 0, 1'b0);
        tag_consume_i = 1'b0;
        cpl_valid_i   = 1'b0;
        n_tmo = 0;
        for (int c = 0; c < 40 && n_tmo < 2; c++) begin
            @(negedge clk);
            if (tmo_valid_o) begin
                tmo_tags[n_tmo] = int'(tmo_tag_o);
                tmo_cyc[n_tmo]  = c;
                n_tmo++;
            end
        end
        chk("tmo pulses", n_tmo, 2);
        if (n_tmo == 2) begin
            chk("tmo first tag", tmo_tags[0], 0);
            chk("tmo second tag", tmo_tags[1], 1);
            chk("tmo consecutive", tmo_cyc[1] - tmo_cyc[0], 1);
        end
        @(negedge clk);
        chk("tmo outstanding", outstanding_o, 0);
        chk("tmo tag_valid", tag_valid_o, 1);
        chk("tmo tag", tag_o, 0);
        for (int i = 0; i < int'(NUM_TAGS); i++) m_busy[i] = 1'b0;
        m_cnt = 0;
        model_pick();
        cycle(1'b0, '0, 1'b1, 0, 1'b1);
        chk("late cpl err", cpl_rsp_err_o, 1);
`else
        // Three allocations.
        cycle(1'b1, 16'h0010, 1'b0, 0, 1'b0);
        cycle(1'b1, 16'h0020, 1'b0, 0, 1'b0);
        cycle(1'b1, 16'h0030, 1'b0, 0, 1'b0);
        chk("alloc3 tag", tag_o, 3);
        chk("alloc3 outstanding", outstanding_o, 3);
        // Final completion on tag 1.
        cycle(1'b0, '0, 1'b1, 1, 1'b1);
        chk("cpl1 valid", cpl_rsp_valid_o, 1);
        chk("cpl1 meta", cpl_rsp_meta_o, 16'h0020);
        chk("cpl1 err", cpl_rsp_err_o, 0);
        chk("cpl1 tag", tag_o, 1);
        chk("cpl1 outstanding", outstanding_o, 2);
        // Free in-range tag, out-of-range tag, then a non-last completion.
        cycle(1'b0, '0, 1'b1, 5, 1'b1);
        chk("cpl free err", cpl_rsp_err_o, 1);
        chk("cpl free outstanding", outstanding_o, 2);
        cycle(1'b0, '0, 1'b1, 9, 1'b1);
        chk("cpl range err", cpl_rsp_err_o, 1);
        cycle(1'b0, '0, 1'b1, 0, 1'b0);
        chk("cpl0 meta", cpl_rsp_meta_o, 16'h0010);
        chk("cpl0 err", cpl_rsp_err_o, 0);
        chk("cpl0 outstanding", outstanding_o, 2);
        // Fill the table, then overflow.
        for (int i = 0; i < 4; i++) cycle(1'b1, META_W'(16'h0100 + i), 1'b0, 0, 1'b0);
        chk("full tag_valid", tag_valid_o, 0);
        chk("full outstanding", outstanding_o, NUM_TAGS);
        cycle(1'b1, 16'hdead, 1'b0, 0, 1'b0);
        chk("overflow alloc_err", alloc_err_o, 1);
        chk("overflow outstanding", outstanding_o, NUM_TAGS);
        // Free tag 3, then consume it while releasing tag 2.
        cycle(1'b0, '0, 1'b1, 3, 1'b1);
        chk("rel3 tag", tag_o, 3);
        cycle(1'b1, 16'h0333, 1'b1, 2, 1'b1);
        chk("swap outstanding", outstanding_o, NUM_TAGS - 1);
        chk("swap tag", tag_o, 2);
        chk("swap tag_valid", tag_valid_o, 1);
        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 9) < 6);
            rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, NUM_TAGS - 1));
            cycle(rc, META_W'($urandom), rv, rt, rl);
        end
        // Reset with tags outstanding; late completion must be an error.
        cycle(1'b1, 16'h1234, 1'b0, 0, 1'b0);
        bt = -1;
        for (int i = 0; i < int'(NUM_TAGS); i++) if (m_busy[i]) bt = i;
        cycle(1'b0, '0, 1'b0, 0, 1'b0);
        cycle(1'b0, '0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset tag_valid", tag_valid_o, 1);
        chk("midreset tag", tag_o, 0);
        chk("midreset outstanding", outstanding_o, 0);
        chk("midreset alloc_err", alloc_err_o, 0);
        chk("midreset rsp_valid", cpl_rsp_valid_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, bt, 1'b1);
        chk("post-reset cpl err", cpl_rsp_err_o, 1);
`endif
        cycle(1'b0, '0, 1'b0, 0, 1'b0);
        cycle(1'b0, '0, 1'b0, 0, 1'b0);
        chk("responses drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
